noc_link_arbiter: RTL and testbench
===================================

Name: noc_link_arbiter

Overview:
- Shares one 64-bit valid/ready inter-chip repeater link among NUM_CH NoC channels.
- Arbitration is round-robin at packet granularity. A granted channel keeps the link until its whole packet (header plus LEN body flits) has transferred.
- Each flit leaves with its channel id so the far-side demux can restore per-NoC ordering.
- Sits upstream of the repeater; the repeater checker sees out_val/out_rdy/out_dat as its input channel.

Parameters:
- NUM_CH, 3, number of requesting NoC channels (2..4).
- DATA_WIDTH, 64, flit width.
- LEN_LSB, 22, bit position of the payload-length field in a header flit.
- LEN_WIDTH, 8, width of the payload-length field (body flits following the header).
- CH_W, 2, width of the channel-id output (must satisfy 2^CH_W >= NUM_CH).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- in_val  input  NUM_CH  per-channel flit valid
- in_dat  input  NUM_CH*DATA_WIDTH  per-channel flit data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_rdy  output  NUM_CH  per-channel ready; at most one bit is set
- out_val  output  1  link flit valid
- out_dat  output  DATA_WIDTH  link flit data
- out_chan  output  CH_W  source channel of the current flit
- out_rdy  input  1  link ready
- busy  output  1  high when a grant is held (state != IDLE)

Behaviour:
- A transfer occurs when out_val & out_rdy are both high. Datapath is combinational: zero added latency, no storage.
- Mux rules:
  - out_dat = in_dat[sel]; out_chan = sel.
  - out_val = in_val[sel] & granted.
  - in_rdy[sel] = out_rdy & granted; all other in_rdy bits are 0.
- Registered state: state, sel, last (last packet-complete grant), remaining (LEN_WIDTH bits).
- States:
  - IDLE:
    - Winner = first set in_val scanning last+1, last+2, ... modulo NUM_CH.
    - If any in_val is set: sel = winner combinationally, granted = 1, out_val = 1.
    - If the header transfers: latch sel and remaining = header LEN.
      - LEN == 0: stay IDLE, last <= sel.
      - Otherwise go to BODY.
    - If the header does not transfer: latch sel and go to HDR.
    - If no in_val is set: out_val = 0, all in_rdy = 0.
  - HDR:
    - Grant is held on the latched sel; out_val = in_val[sel]. Other channels cannot steal the grant even if they have higher round-robin priority.
    - On transfer: LEN == 0 -> IDLE and last <= sel; else remaining <= LEN and go to BODY.
  - BODY:
    - Grant is held on sel.
    - Each transfer decrements remaining.
    - A transfer with remaining == 1 -> IDLE, last <= sel.
    - If in_val[sel] drops mid-packet, out_val is 0 and the grant stays held; bubbles are allowed.
- LEN is taken from in_dat[sel][LEN_LSB +: LEN_WIDTH] of the header flit only. Maximum LEN (255) gives 256 flits, with no wrap of remaining below 0.
- Upstream must hold in_val and in_dat stable until transfer. The arbiter never retracts out_val once it has presented a flit.
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE, sel = 0, remaining = 0, last = NUM_CH-1, so channel 0 has first priority.
  - While rst_n is low: out_val = 0, in_rdy = 0, busy = 0, out_chan = 0.
  - Reset mid-packet abandons the packet; no partial-packet recovery is attempted.
- busy = (state == HDR) | (state == BODY).

Test Plan:
- Single channel: ch1 sends header LEN=2 plus 2 body flits, out_rdy=1 -> 3 consecutive transfers with out_chan=1; busy high for 2 cycles; return to IDLE; last=1.
- Contention: ch0, ch1 and ch2 all hold valid single-flit packets (LEN=0) from reset -> grant order 0, 1, 2, 0, ... with one flit per cycle.
- Packet lock: ch0 sends LEN=3 while ch2 is valid throughout -> ch2 is not granted until the 4th ch0 flit transfers; ch2 is granted the next cycle.
- Backpressure:
  - out_rdy=0 for 5 cycles at the header -> state HDR, sel stable, in_rdy all 0; when out_rdy=1 the header transfers from the same channel.
  - A higher-priority channel raising in_val during the stall must not steal the grant.
- Bubble mid-packet: ch2 header LEN=2, then in_val[2] drops for 3 cycles -> out_val=0 and busy=1 throughout; the packet completes with 2 body flits.
- Reset mid-packet: rst_n low during BODY with remaining=4 -> next cycle out_val=0, busy=0; after release, first grant goes to ch0.

Source files
------------

// File: rtl/noc_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one valid/ready link among NUM_CH NoC channels.
// Combinational datapath; registered grant state tracks header/body progress per packet.
module noc_link_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_LSB    = 22,
    parameter int LEN_WIDTH  = 8,
    parameter int CH_W       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_val,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_dat,
    output logic [NUM_CH-1:0]            in_rdy,
    output logic                         out_val,
    output logic [DATA_WIDTH-1:0]        out_dat,
    output logic [CH_W-1:0]              out_chan,
    input  logic                         out_rdy,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                state_reg, state_next;
    logic [CH_W-1:0]       sel_reg, sel_next;
    logic [CH_W-1:0]       last_reg, last_next;
    logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;

    logic [CH_W-1:0]       winner;
    logic [CH_W-1:0]       sel_cur;
    logic                  any_val;
    logic                  granted;
    logic                  xfer;
    logic [LEN_WIDTH-1:0]  hdr_len;
    logic [DATA_WIDTH-1:0] ch_dat [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_dat[gi] = in_dat[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_rdy[gi] = rst_n & granted & out_rdy & (sel_cur == CH_W'(gi));
        end
    endgenerate

    assign any_val = |in_val;

    // Scan from last+NUM_CH down to last+1 so the nearest requester after last wins.
    always_comb begin
        winner = last_reg;
        for (int l = 0; l < NUM_CH; l++) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                if (last_reg == CH_W'(l) && in_val[(l + k) % NUM_CH]) begin
                    winner = CH_W'((l + k) % NUM_CH);
                end
            end
        end
    end

    always_comb begin
        sel_cur = sel_reg;
        granted = 1'b1;
        if (state_reg == IDLE) begin
            sel_cur = winner;
            granted = any_val;
        end
    end

    assign out_val  = rst_n & granted & in_val[sel_cur];
    assign out_dat  = ch_dat[sel_cur];
    assign out_chan = rst_n ? sel_cur : '0;
    assign busy     = rst_n & (state_reg != IDLE);
    assign xfer     = out_val & out_rdy;
    assign hdr_len  = ch_dat[sel_cur][LEN_LSB +: LEN_WIDTH];

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        last_next      = last_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    sel_next       = winner;
                    remaining_next = hdr_len;
                    if (hdr_len == '0) begin
                        last_next = winner;
                    end else begin
                        state_next = BODY;
                    end
                end else if (any_val) begin
                    sel_next   = winner;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    remaining_next = hdr_len;
                    if (hdr_len == '0) begin
                        state_next = IDLE;
                        last_next  = sel_reg;
                    end else begin
                        state_next = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = IDLE;
                        last_next  = sel_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            last_reg      <= CH_W'(NUM_CH - 1);
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            last_reg      <= last_next;
            remaining_reg <= remaining_next;
        end
    end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Directed-vector bench for noc_link_arbiter: one task per scenario, inline checks.
module tb_noc_link_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_val;
    logic [191:0] in_dat;
    logic [2:0]   in_rdy;
    logic         out_val;
    logic [63:0]  out_dat;
    logic [1:0]   out_chan;
    logic         out_rdy;
    logic         busy;

    int errors = 0;
    int checks = 0;

    noc_link_arbiter dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_dat(in_dat), .in_rdy(in_rdy),
        .out_val(out_val), .out_dat(out_dat), .out_chan(out_chan), .out_rdy(out_rdy), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk_hdr(input logic [7:0] len, input logic [7:0] tag);
        logic [63:0] h;
        h = 64'h0;
        h[63:56] = 8'hA5;
        h[29:22] = len;
        h[7:0]   = tag;
        return h;
    endfunction

    task automatic set_dat(input int ch, input logic [63:0] d);
        in_dat[ch*64 +: 64] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_val = 3'b000; out_rdy = 1'b0; in_dat = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_rdy = 1'b1; in_val = 3'b111;
        set_dat(0, mk_hdr(8'd0, 8'h00)); set_dat(1, mk_hdr(8'd0, 8'h01)); set_dat(2, mk_hdr(8'd0, 8'h02));
        tick(); tick(); #1;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        checks++; if (in_rdy !== 3'b000) begin errors++; $display("FAIL reset_in_rdy got=%b exp=000", in_rdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
        rst_n = 1'b1; #1;
        checks++; if (out_chan !== 2'd0 || out_val !== 1'b1) begin errors++; $display("FAIL reset_first_grant got chan=%0d val=%b exp chan=0 val=1", out_chan, out_val); end
        $display("test_reset: first grant chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_single();
        do_reset();
        in_val = 3'b010; out_rdy = 1'b1; set_dat(1, mk_hdr(8'd2, 8'h11)); #1;
        checks++; if (out_val !== 1'b1 || out_chan !== 2'd1) begin errors++; $display("FAIL single_hdr got val=%b chan=%0d exp val=1 chan=1", out_val, out_chan); end
        checks++; if (in_rdy !== 3'b010 || busy !== 1'b0) begin errors++; $display("FAIL single_hdr_rdy got rdy=%b busy=%b exp rdy=010 busy=0", in_rdy, busy); end
        checks++; if (out_dat !== mk_hdr(8'd2, 8'h11)) begin errors++; $display("FAIL single_hdr_dat got=%h exp=%h", out_dat, mk_hdr(8'd2, 8'h11)); end
        $display("single: hdr chan=%0d dat=%h", out_chan, out_dat);
        for (int i = 1; i <= 2; i++) begin
            tick(); set_dat(1, 64'hB0 + 64'(i)); #1;
            checks++; if (out_val !== 1'b1 || out_chan !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL single_body%0d got val=%b chan=%0d busy=%b exp val=1 chan=1 busy=1", i, out_val, out_chan, busy); end
            checks++; if (out_dat !== 64'hB0 + 64'(i) || in_rdy !== 3'b010) begin errors++; $display("FAIL single_body%0d_dat got dat=%h rdy=%b exp dat=%h rdy=010", i, out_dat, in_rdy, 64'hB0 + 64'(i)); end
            $display("single: body%0d chan=%0d dat=%h", i, out_chan, out_dat);
        end
        tick();
        in_val = 3'b111;
        set_dat(0, mk_hdr(8'd0, 8'h20)); set_dat(1, mk_hdr(8'd0, 8'h21)); set_dat(2, mk_hdr(8'd0, 8'h22)); #1;
        checks++; if (busy !== 1'b0 || out_chan !== 2'd2) begin errors++; $display("FAIL single_last got busy=%b chan=%0d exp busy=0 chan=2", busy, out_chan); end
        $display("single: after packet next grant chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_contention();
        logic [2:0] exp_rdy;
        do_reset();
        set_dat(0, mk_hdr(8'd0, 8'h30)); set_dat(1, mk_hdr(8'd0, 8'h31)); set_dat(2, mk_hdr(8'd0, 8'h32));
        in_val = 3'b111; out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = 3'b001 << (i % 3);
            checks++; if (out_chan !== 2'(i % 3) || in_rdy !== exp_rdy || out_val !== 1'b1) begin errors++; $display("FAIL contention_%0d got chan=%0d rdy=%b val=%b exp chan=%0d rdy=%b val=1", i, out_chan, in_rdy, out_val, i % 3, exp_rdy); end
            $display("contention: cycle %0d chan=%0d", i, out_chan);
            tick();
        end
        in_val = 3'b000; tick();
    endtask

    task automatic test_packet_lock();
        do_reset();
        set_dat(0, mk_hdr(8'd3, 8'h40)); set_dat(2, mk_hdr(8'd0, 8'h42));
        in_val = 3'b101; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_chan !== 2'd0 || in_rdy !== 3'b001 || busy !== (i > 0)) begin errors++; $display("FAIL lock_%0d got chan=%0d rdy=%b busy=%b exp chan=0 rdy=001 busy=%b", i, out_chan, in_rdy, busy, i > 0); end
            $display("lock: flit %0d chan=%0d", i, out_chan);
            tick();
        end
        #1;
        checks++; if (out_chan !== 2'd2 || in_rdy !== 3'b100 || busy !== 1'b0) begin errors++; $display("FAIL lock_next got chan=%0d rdy=%b busy=%b exp chan=2 rdy=100 busy=0", out_chan, in_rdy, busy); end
        $display("lock: next grant chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_dat(0, mk_hdr(8'd0, 8'h50)); set_dat(1, mk_hdr(8'd0, 8'h51));
        in_val = 3'b010; out_rdy = 1'b0; #1;
        checks++; if (out_val !== 1'b1 || out_chan !== 2'd1 || in_rdy !== 3'b000) begin errors++; $display("FAIL bp_idle got val=%b chan=%0d rdy=%b exp val=1 chan=1 rdy=000", out_val, out_chan, in_rdy); end
        tick();
        in_val = 3'b011;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (busy !== 1'b1 || out_chan !== 2'd1 || in_rdy !== 3'b000 || out_val !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got busy=%b chan=%0d rdy=%b val=%b exp busy=1 chan=1 rdy=000 val=1", i, busy, out_chan, in_rdy, out_val); end
            $display("backpressure: stall %0d chan=%0d", i, out_chan);
            tick();
        end
        out_rdy = 1'b1; #1;
        checks++; if (in_rdy !== 3'b010 || out_chan !== 2'd1 || out_dat !== mk_hdr(8'd0, 8'h51)) begin errors++; $display("FAIL bp_release got rdy=%b chan=%0d dat=%h exp rdy=010 chan=1 dat=%h", in_rdy, out_chan, out_dat, mk_hdr(8'd0, 8'h51)); end
        tick(); #1;
        checks++; if (out_chan !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL bp_next got chan=%0d busy=%b exp chan=0 busy=0", out_chan, busy); end
        $display("backpressure: released, next chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_bubble();
        do_reset();
        set_dat(2, mk_hdr(8'd2, 8'h62)); set_dat(0, mk_hdr(8'd0, 8'h60));
        in_val = 3'b100; out_rdy = 1'b1; #1;
        checks++; if (out_chan !== 2'd2 || out_val !== 1'b1) begin errors++; $display("FAIL bubble_hdr got chan=%0d val=%b exp chan=2 val=1", out_chan, out_val); end
        tick();
        in_val = 3'b001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_val !== 1'b0 || busy !== 1'b1 || out_chan !== 2'd2) begin errors++; $display("FAIL bubble_gap%0d got val=%b busy=%b chan=%0d exp val=0 busy=1 chan=2", i, out_val, busy, out_chan); end
            $display("bubble: gap %0d val=%b busy=%b", i, out_val, busy);
            tick();
        end
        in_val = 3'b101;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (out_val !== 1'b1 || busy !== 1'b1 || out_chan !== 2'd2) begin errors++; $display("FAIL bubble_body%0d got val=%b busy=%b chan=%0d exp val=1 busy=1 chan=2", i, out_val, busy, out_chan); end
            tick();
        end
        #1;
        checks++; if (out_chan !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL bubble_done got chan=%0d busy=%b exp chan=0 busy=0", out_chan, busy); end
        $display("bubble: packet done, next chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_max_len();
        do_reset();
        set_dat(0, mk_hdr(8'd255, 8'h70)); set_dat(1, mk_hdr(8'd0, 8'h71));
        in_val = 3'b011; out_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            #1;
            checks++; if (out_chan !== 2'd0 || out_val !== 1'b1 || busy !== (i > 0)) begin errors++; $display("FAIL maxlen_%0d got chan=%0d val=%b busy=%b exp chan=0 val=1 busy=%b", i, out_chan, out_val, busy, i > 0); end
            tick();
        end
        #1;
        checks++; if (out_chan !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL maxlen_end got chan=%0d busy=%b exp chan=1 busy=0", out_chan, busy); end
        $display("max_len: 256 flits from chan 0, next chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_dat(0, mk_hdr(8'd0, 8'h80));
        in_val = 3'b001; out_rdy = 1'b1;
        tick();
        set_dat(1, mk_hdr(8'd6, 8'h81)); in_val = 3'b010;
        tick(); tick(); tick(); #1;
        checks++; if (busy !== 1'b1 || out_chan !== 2'd1) begin errors++; $display("FAIL rstmid_body got busy=%b chan=%0d exp busy=1 chan=1", busy, out_chan); end
        set_dat(0, mk_hdr(8'd0, 8'h90)); set_dat(1, mk_hdr(8'd0, 8'h91));
        in_val = 3'b011; rst_n = 1'b0;
        tick();
        checks++; if (out_val !== 1'b0 || busy !== 1'b0 || in_rdy !== 3'b000) begin errors++; $display("FAIL rstmid_reset got val=%b busy=%b rdy=%b exp val=0 busy=0 rdy=000", out_val, busy, in_rdy); end
        rst_n = 1'b1; #1;
        checks++; if (out_chan !== 2'd0 || in_rdy !== 3'b001 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after got chan=%0d rdy=%b busy=%b exp chan=0 rdy=001 busy=0", out_chan, in_rdy, busy); end
        $display("reset_mid: after release first grant chan=%0d", out_chan);
        in_val = 3'b000; tick();
    endtask

    initial begin
        rst_n = 1'b0; in_val = 3'b000; in_dat = '0; out_rdy = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_backpressure();
        test_bubble();
        test_max_len();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
